// File: rtl/ex_mem_stage_hs.sv
// EX->MEM pipeline register with valid/ready handshake, synchronous flush
// and an optional 2-entry skid buffer (main entry drives the outputs).
module ex_mem_stage_hs #(
  parameter int CTRL_W  = 24,
  parameter int DATA_W  = 32,
  parameter int DEST_W  = 5,
  parameter int SKID_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] control_signals,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] PB,
  input  logic [DEST_W-1:0] destination,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] control_signals_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] PB_out,
  output logic [DEST_W-1:0] destination_out,
  output logic [1:0]        occupancy
);

  localparam int PAY_W = CTRL_W + 2 * DATA_W + DEST_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [PAY_W-1:0] main_q;
  logic [PAY_W-1:0] skid_q;
  logic [PAY_W-1:0] pay_in;
  logic             acc;
  logic             deq;
  logic             load_main_in;
  logic             load_main_skid;
  logic             load_skid_in;
  logic             clear_main;
  logic             clear_skid;

  assign pay_in    = {control_signals, alu_result, PB, destination};
  assign out_valid = (state != EMPTY);
  assign acc       = in_valid && in_ready;
  assign deq       = out_valid && out_ready;
  assign occupancy = (state == FULL) ? 2'd2 : ((state == ONE) ? 2'd1 : 2'd0);

  // Payload registers are zeroed whenever their entry goes invalid, so the
  // outputs read as all-zero bubbles without any output masking.
  assign {control_signals_out, alu_result_out, PB_out, destination_out} = main_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= EMPTY;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    clear_main     = 1'b0;
    clear_skid     = 1'b0;
    if (flush) begin
      next_state = EMPTY;
      clear_main = 1'b1;
      clear_skid = 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (acc) begin
            load_main_in = 1'b1;
            next_state   = ONE;
          end
        end
        ONE: begin
          if (acc && deq) begin
            load_main_in = 1'b1;
          end else if (acc && (SKID_EN != 0)) begin
            load_skid_in = 1'b1;
            next_state   = FULL;
          end else if (deq) begin
            clear_main = 1'b1;
            next_state = EMPTY;
          end
        end
        FULL: begin
          if (deq) begin
            load_main_skid = 1'b1;
            clear_skid     = 1'b1;
            next_state     = ONE;
          end
        end
        default: begin
          next_state = EMPTY;
          clear_main = 1'b1;
          clear_skid = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (clear_main) begin
        main_q <= '0;
      end else if (load_main_in) begin
        main_q <= pay_in;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (clear_skid) begin
        skid_q <= '0;
      end else if (load_skid_in) begin
        skid_q <= pay_in;
      end
    end
  end

  // With the skid buffer, in_ready is its own flop so MEM's out_ready never
  // reaches EX combinationally; it mirrors "skid entry empty".
  generate
    if (SKID_EN != 0) begin : g_skid
      logic ready_q;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          ready_q <= 1'b1;
        end else begin
          ready_q <= (next_state != FULL);
        end
      end
      assign in_ready = ready_q;
    end else begin : g_noskid
      assign in_ready = (state == EMPTY) || out_ready;
    end
  endgenerate

endmodule

// File: tb/tb_ex_mem_stage_hs.sv
// Scoreboard bench for ex_mem_stage_hs: a skid and a no-skid instance share
// stimulus; each has a FIFO reference model of the entries it holds.
module tb_ex_mem_stage_hs;

  localparam int CTRL_W = 24;
  localparam int DATA_W = 32;
  localparam int DEST_W = 5;
  localparam int PAY_W  = CTRL_W + 2 * DATA_W + DEST_W;
  localparam int DEPTH  = 16;

  typedef logic [PAY_W-1:0] pay_t;

  logic              clk;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] ctrl_in;
  logic [DATA_W-1:0] alu_in;
  logic [DATA_W-1:0] pb_in;
  logic [DEST_W-1:0] dest_in;

  logic              rdy_s, ov_s, rdy_n, ov_n;
  logic [1:0]        occ_s, occ_n;
  logic [CTRL_W-1:0] ctrl_s, ctrl_n;
  logic [DATA_W-1:0] alu_s, alu_n, pb_s, pb_n;
  logic [DEST_W-1:0] dest_s, dest_n;

  logic       rdy_a [2];
  logic       ov_a  [2];
  logic [1:0] occ_a [2];
  pay_t       pay_a [2];

  pay_t model_mem [2][DEPTH];
  int   model_hd  [2];
  int   model_cnt [2];

  int   checks;
  int   failures;
  logic mon_en;

  ex_mem_stage_hs #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .DEST_W(DEST_W), .SKID_EN(1)) u_skid (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy_s),
    .control_signals(ctrl_in), .alu_result(alu_in), .PB(pb_in), .destination(dest_in),
    .out_valid(ov_s), .out_ready(out_ready), .control_signals_out(ctrl_s),
    .alu_result_out(alu_s), .PB_out(pb_s), .destination_out(dest_s), .occupancy(occ_s)
  );

  ex_mem_stage_hs #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .DEST_W(DEST_W), .SKID_EN(0)) u_noskid (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy_n),
    .control_signals(ctrl_in), .alu_result(alu_in), .PB(pb_in), .destination(dest_in),
    .out_valid(ov_n), .out_ready(out_ready), .control_signals_out(ctrl_n),
    .alu_result_out(alu_n), .PB_out(pb_n), .destination_out(dest_n), .occupancy(occ_n)
  );

  assign rdy_a[0] = rdy_s;
  assign rdy_a[1] = rdy_n;
  assign ov_a[0]  = ov_s;
  assign ov_a[1]  = ov_n;
  assign occ_a[0] = occ_s;
  assign occ_a[1] = occ_n;
  assign pay_a[0] = {ctrl_s, alu_s, pb_s, dest_s};
  assign pay_a[1] = {ctrl_n, alu_n, pb_n, dest_n};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int d, input logic [127:0] act,
                             input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s dut%0d got=%0h expected=%0h at %0t", name, d, act, exp, $time);
    end
  endtask

  function automatic pay_t make_pay(input logic [31:0] alu);
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    make_pay = {r[CTRL_W-1:0], alu, r[63:32], r[68:64]};
  endfunction

  function automatic pay_t rand_pay();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    rand_pay = r[PAY_W-1:0];
  endfunction

  task automatic clear_models();
    for (int d = 0; d < 2; d++) begin
      model_hd[d]  = 0;
      model_cnt[d] = 0;
    end
  endtask

  // Drive one cycle of inputs; once the handshake is settled, record accepted
  // entries in the model (or drop everything on flush).
  task automatic applyStimulus(input logic v, input pay_t p, input logic f, input logic ordy);
    in_valid  = v;
    {ctrl_in, alu_in, pb_in, dest_in} = p;
    flush     = f;
    out_ready = ordy;
    @(negedge clk);
    #2;
    for (int d = 0; d < 2; d++) begin
      if (f) begin
        model_hd[d]  = 0;
        model_cnt[d] = 0;
      end else if (v && rdy_a[d]) begin
        model_mem[d][(model_hd[d] + model_cnt[d]) % DEPTH] = p;
        model_cnt[d]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every mid-cycle compare presented outputs against the model head,
  // and retire the head when MEM takes it.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        int   size;
        logic exp_rdy;
        pay_t exp_head;
        size     = model_cnt[d];
        exp_head = (size > 0) ? model_mem[d][model_hd[d]] : '0;
        exp_rdy  = (d == 0) ? (size < 2) : ((size == 0) || out_ready);
        checkOutput("out_valid", d, 128'(ov_a[d]), 128'(size > 0));
        checkOutput("occupancy", d, 128'(occ_a[d]), 128'(size));
        checkOutput("in_ready", d, 128'(rdy_a[d]), 128'(exp_rdy));
        checkOutput("payload", d, 128'(pay_a[d]), 128'(exp_head));
        if (ov_a[d] && out_ready && !flush && (model_cnt[d] > 0)) begin
          model_hd[d] = (model_hd[d] + 1) % DEPTH;
          model_cnt[d]--;
        end
      end
    end
  end

  initial begin
    pay_t a, b;
    checks    = 0;
    failures  = 0;
    mon_en    = 1'b0;
    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    {ctrl_in, alu_in, pb_in, dest_in} = '0;
    clear_models();

    #12;
    for (int d = 0; d < 2; d++) begin
      checkOutput("reset_out_valid", d, 128'(ov_a[d]), 128'(0));
      checkOutput("reset_occupancy", d, 128'(occ_a[d]), 128'(0));
      checkOutput("reset_payload", d, 128'(pay_a[d]), 128'(0));
    end
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Pass-through with MEM always ready.
    applyStimulus(1'b1, make_pay(32'h0000_0011), 1'b0, 1'b1);
    applyStimulus(1'b1, make_pay(32'h0000_0022), 1'b0, 1'b1);
    applyStimulus(1'b1, make_pay(32'h0000_0033), 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);

    // Backpressure fills the skid entry, then drains in order.
    applyStimulus(1'b1, make_pay(32'hAAAA_0001), 1'b0, 1'b0);
    applyStimulus(1'b1, make_pay(32'hBBBB_0002), 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1);

    // Flush while full, with a competing input and dequeue.
    applyStimulus(1'b1, make_pay(32'h1234_0001), 1'b0, 1'b0);
    applyStimulus(1'b1, make_pay(32'h1234_0002), 1'b0, 1'b0);
    applyStimulus(1'b1, make_pay(32'hDEAD_BEEF), 1'b1, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);

    // Held entry, then same-cycle replace.
    applyStimulus(1'b1, make_pay(32'h0D0D_0001), 1'b0, 1'b0);
    applyStimulus(1'b1, make_pay(32'h0E0E_0002), 1'b0, 1'b0);
    applyStimulus(1'b1, make_pay(32'h0F0F_0003), 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);

    for (int i = 0; i < 4000; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, rand_pay(), $urandom_range(0, 31) == 0,
                    $urandom_range(0, 2) != 0);
    end

    // Asynchronous reset while the skid instance holds two entries.
    a = make_pay(32'h5555_0001);
    b = make_pay(32'h6666_0002);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b1, a, 1'b0, 1'b0);
    applyStimulus(1'b1, b, 1'b0, 1'b0);
    mon_en   = 1'b0;
    in_valid = 1'b0;
    checkOutput("pre_reset_occupancy", 0, 128'(occ_a[0]), 128'(2));
    #2 reset = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      checkOutput("async_reset_out_valid", d, 128'(ov_a[d]), 128'(0));
      checkOutput("async_reset_occupancy", d, 128'(occ_a[d]), 128'(0));
      checkOutput("async_reset_payload", d, 128'(pay_a[d]), 128'(0));
    end
    clear_models();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      checkOutput("post_reset_in_ready", d, 128'(rdy_a[d]), 128'(1));
      checkOutput("post_reset_out_valid", d, 128'(ov_a[d]), 128'(0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
